// File: rtl/mult4bit_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mult4bit_ctrl_pkg
// Purpose  : Shared state encodings and shift codes for the 4x4 multiplier.
// Revision : 1.0 - initial release
// ============================================================================
package mult4bit_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_PP0  = 3'd2,
        S_PP1  = 3'd3,
        S_PP2  = 3'd4,
        S_PP3  = 3'd5,
        S_DONE = 3'd6
    } state_t;

    localparam logic [1:0] SHAMT_0 = 2'b00;
    localparam logic [1:0] SHAMT_2 = 2'b01;
    localparam logic [1:0] SHAMT_4 = 2'b10;

endpackage
`default_nettype wire

// File: rtl/mult4bit_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mult4bit_ctrl
// Purpose  : Moore controller sequencing four 2x2 partial products.
// Revision : 1.0 - initial release
// ============================================================================
module mult4bit_ctrl
    import mult4bit_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       ld,
    output logic       clr_acc,
    output logic       sela,
    output logic       selb,
    output logic [1:0] shamt,
    output logic       acc_en,
    output logic       busy,
    output logic       done
);

    state_t state_q;
    state_t state_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // start only matters in IDLE and DONE; the partial-product states run blind
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = start ? S_LOAD : S_IDLE;
            S_LOAD:  state_d = S_PP0;
            S_PP0:   state_d = S_PP1;
            S_PP1:   state_d = S_PP2;
            S_PP2:   state_d = S_PP3;
            S_PP3:   state_d = S_DONE;
            S_DONE:  state_d = start ? S_LOAD : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ld      = 1'b0;
        clr_acc = 1'b0;
        sela    = 1'b0;
        selb    = 1'b0;
        shamt   = SHAMT_0;
        acc_en  = 1'b0;
        busy    = (state_q != S_IDLE);
        done    = 1'b0;
        case (state_q)
            S_LOAD: begin
                ld      = 1'b1;
                clr_acc = 1'b1;
            end
            S_PP0: begin
                acc_en = 1'b1;
            end
            S_PP1: begin
                acc_en = 1'b1;
                sela   = 1'b1;
                shamt  = SHAMT_2;
            end
            S_PP2: begin
                acc_en = 1'b1;
                selb   = 1'b1;
                shamt  = SHAMT_2;
            end
            S_PP3: begin
                acc_en = 1'b1;
                sela   = 1'b1;
                selb   = 1'b1;
                shamt  = SHAMT_4;
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire
